// File: rtl/fifo_bus_initiator.sv
// fifo_bus_initiator: turns PUSH/POP/STAT/CLEAR commands into register-bus cycles,
// polling STAT_REG before FIFO accesses so the FIFO never over- or underflows.
module fifo_bus_initiator #(
    parameter int POLL_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       enable,
    output logic [1:0] addr,
    output logic       write,
    output logic       read,
    output logic [7:0] wdata,
    input  logic [7:0] rdata
);
    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd3;
    localparam logic [1:0] A_FIFO   = 2'd0;
    localparam logic [1:0] A_STAT   = 2'd1;
    localparam logic [7:0] LAST_POLL = 8'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {IDLE, CHK, BACKOFF, ACCESS, CAPTURE, RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] polls, polls_nxt;
    logic [7:0] rsp_data_nxt;
    logic       rsp_err_nxt;
    logic       blocked;
    logic       acc_write;
    logic [1:0] acc_addr;

    // STAT and CLEAR target STAT_REG, PUSH and POP target the FIFO
    assign acc_addr  = op[1] ? A_STAT : A_FIFO;
    assign acc_write = (op == OP_PUSH) || (op == OP_CLEAR);
    assign blocked   = (op == OP_PUSH && rdata[0]) || (op == OP_POP && rdata[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= 2'd0;
            data     <= 8'h00;
            polls    <= 8'h00;
            rsp_data <= 8'h00;
            rsp_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            polls    <= polls_nxt;
            rsp_data <= rsp_data_nxt;
            rsp_err  <= rsp_err_nxt;
            if (state == IDLE && cmd_valid) begin
                op   <= cmd_op;
                data <= cmd_data;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        polls_nxt    = polls;
        rsp_data_nxt = rsp_data;
        rsp_err_nxt  = rsp_err;
        case (state)
            IDLE: if (cmd_valid) begin
                state_nxt = cmd_op[1] ? ACCESS : CHK;
                polls_nxt = 8'h00;
            end
            CHK: if (!blocked) begin
                state_nxt = ACCESS;
            end else if (polls == LAST_POLL) begin
                state_nxt    = RESP;
                rsp_data_nxt = rdata;
                rsp_err_nxt  = 1'b1;
            end else begin
                state_nxt = BACKOFF;
                polls_nxt = polls + 8'd1;
            end
            BACKOFF: state_nxt = CHK;
            ACCESS:  state_nxt = CAPTURE;
            CAPTURE: begin
                state_nxt    = RESP;
                rsp_err_nxt  = 1'b0;
                rsp_data_nxt = (op == OP_PUSH) ? data : (op == OP_CLEAR) ? 8'h00 : rdata;
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_ready stays low while reset is asserted
    assign cmd_ready = rst_n && state == IDLE;
    assign rsp_valid = state == RESP;
    assign enable    = state == CHK || state == ACCESS;
    assign read      = state == CHK || (state == ACCESS && !acc_write);
    assign write     = state == ACCESS && acc_write;
    assign addr      = (state == CHK) ? A_STAT :
                       (state == ACCESS || state == CAPTURE) ? acc_addr : A_FIFO;
    assign wdata     = (state == ACCESS && op == OP_PUSH)  ? data  :
                       (state == ACCESS && op == OP_CLEAR) ? 8'h10 : 8'h00;
endmodule

// File: tb/tb_fifo_bus_initiator.sv
// tb_fifo_bus_initiator: drives random and directed commands into fifo_bus_initiator
// against a 4-deep FIFO bus target and a transaction-level expected-cycle model.
module tb_fifo_bus_initiator;
    localparam int PL = 4;
    localparam int DEPTH = 4;

    logic clk = 0, rst_n = 0, cmd_valid = 0, rsp_ready = 0;
    logic [1:0] cmd_op = 0;
    logic [7:0] cmd_data = 0;
    logic cmd_ready, rsp_valid, rsp_err, enable, write, read;
    logic [1:0] addr;
    logic [7:0] rsp_data, wdata, rdata;

    always #5 clk = ~clk;

    fifo_bus_initiator #(.POLL_LIMIT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .enable(enable), .addr(addr),
        .write(write), .read(read), .wdata(wdata), .rdata(rdata)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Bus target: FIFO at addr 0 with a registered output, status at addr 1
    logic [7:0] s_q[$];
    int s_cnt = 0;
    logic [7:0] s_out = 0;
    logic s_ovf = 0, force_ovf = 0;

    always @(posedge clk) begin
        if (force_ovf) s_ovf <= 1'b1;
        if (enable && write && addr == 2'd0) begin
            if (s_cnt == DEPTH) s_ovf <= 1'b1;
            else begin
                s_q.push_back(wdata);
                s_cnt <= s_cnt + 1;
            end
        end
        if (enable && read && addr == 2'd0 && s_cnt != 0) begin
            s_out <= s_q[0];
            void'(s_q.pop_front());
            s_cnt <= s_cnt - 1;
        end
        if (enable && write && addr == 2'd1 && wdata[4]) begin
            s_q.delete();
            s_cnt <= 0;
            s_ovf <= 1'b0;
        end
    end
    assign rdata = (addr == 2'd1) ? {5'b0, s_ovf, s_cnt == 0, s_cnt == DEPTH} : s_out;

    // Reference model: per accepted command, the list of expected bus cycles and the response
    typedef struct packed {logic en, rd, wr; logic [1:0] a; logic [7:0] wd;} bus_t;
    bus_t exp_q[$];
    logic [7:0] m_q[$];
    logic m_ovf = 0, exp_err = 0;
    logic [7:0] exp_data = 0;
    int mode = 0, acc_cnt = 0, rsp_cnt = 0, cyc = 0, acc_cyc = 0;

    function automatic bus_t mk(logic en, logic rd, logic wr, logic [1:0] a, logic [7:0] wd);
        return {en, rd, wr, a, wd};
    endfunction

    function automatic void apply(bus_t e);
        if (e.en && e.wr && e.a == 2'd0) m_q.push_back(e.wd);
        if (e.en && e.rd && e.a == 2'd0) void'(m_q.pop_front());
        if (e.en && e.wr && e.a == 2'd1 && e.wd[4]) begin
            m_q.delete();
            m_ovf = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0;
            exp_q.delete();
        end else begin
            logic [7:0] st;
            cyc++;
            if (force_ovf) m_ovf = 1'b1;
            st = {5'b0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH};
            if (mode == 0) begin
                if (cmd_valid) begin
                    acc_cnt++;
                    acc_cyc = cyc;
                    mode = 1;
                    if (cmd_op < 2 && st[cmd_op]) begin
                        for (int i = 0; i < PL; i++) begin
                            exp_q.push_back(mk(1, 1, 0, 2'd1, 8'h00));
                            if (i < PL - 1) exp_q.push_back(mk(0, 0, 0, 2'd0, 8'h00));
                        end
                        exp_data = st;
                        exp_err = 1'b1;
                    end else begin
                        if (cmd_op < 2) exp_q.push_back(mk(1, 1, 0, 2'd1, 8'h00));
                        case (cmd_op)
                            2'd0: begin exp_q.push_back(mk(1, 0, 1, 2'd0, cmd_data)); exp_q.push_back(mk(0, 0, 0, 2'd0, 8'h00)); exp_data = cmd_data; end
                            2'd1: begin exp_q.push_back(mk(1, 1, 0, 2'd0, 8'h00)); exp_q.push_back(mk(0, 0, 0, 2'd0, 8'h00)); exp_data = m_q[0]; end
                            2'd2: begin exp_q.push_back(mk(1, 1, 0, 2'd1, 8'h00)); exp_q.push_back(mk(0, 0, 0, 2'd1, 8'h00)); exp_data = st; end
                            default: begin exp_q.push_back(mk(1, 0, 1, 2'd1, 8'h10)); exp_q.push_back(mk(0, 0, 0, 2'd1, 8'h00)); exp_data = 8'h00; end
                        endcase
                        exp_err = 1'b0;
                    end
                end
            end else if (mode == 1) begin
                apply(exp_q[0]);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) mode = 2;
            end else if (rsp_ready) begin
                mode = 0;
                rsp_cnt++;
            end
        end
    end

    // Per-cycle compare plus observation counters for the directed checks
    int n_chk = 0, n_a0 = 0, n_clr = 0, n_en = 0, lat = 0;
    logic prev_rv = 0, obs_err = 0;
    logic [7:0] obs_data = 0;

    always @(negedge clk) begin
        if (!rst_n) prev_rv = 0;
        else begin
            bus_t e;
            e = (mode == 1) ? exp_q[0] : '0;
            chk("bus", {cmd_ready, rsp_valid, enable, read, write, addr, wdata}, {mode == 0, mode == 2, e});
            if (mode == 2) chk("rsp", {rsp_err, rsp_data}, {exp_err, exp_data});
            if (enable && read && addr == 2'd1) n_chk++;
            if ((read || write) && addr == 2'd0) n_a0++;
            if (write && addr == 2'd1 && wdata == 8'h10) n_clr++;
            if (enable) n_en++;
            if (rsp_valid && !prev_rv) lat = cyc - acc_cyc + 1;
            if (rsp_valid) begin
                obs_data = rsp_data;
                obs_err = rsp_err;
            end
            prev_rv = rsp_valid;
        end
    end

    int bp_mode = 0;
    initial forever begin
        @(negedge clk);
        #1;
        rsp_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    int rsp_base = 0;
    task automatic send(input logic [1:0] op, input logic [7:0] d);
        int n;
        n = acc_cnt;
        rsp_base = rsp_cnt;
        @(negedge clk);
        #1;
        cmd_valid = 1;
        cmd_op = op;
        cmd_data = d;
        for (int i = 0; i < 64 && acc_cnt == n; i++) @(negedge clk);
        chk("accept", 16'(acc_cnt - n), 16'd1);
        #1;
        cmd_valid = 0;
        cmd_op = 2'($urandom);
        cmd_data = 8'($urandom);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 400 && rsp_cnt == rsp_base; i++) @(negedge clk);
        chk("rsp_timeout", 16'(rsp_cnt - rsp_base), 16'd1);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] d);
        send(op, d);
        wait_rsp();
    endtask

    initial begin
        automatic logic [7:0] fill[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int c0, a0, w0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {cmd_ready, rsp_valid, enable, read, write, addr, wdata, rsp_err}, 16'h0);
        chk("reset_rsp_data", 16'(rsp_data), 16'h0);
        #1 rst_n = 1;
        c0 = n_en;
        repeat (20) @(negedge clk);
        chk("idle_no_bus", 16'(n_en - c0), 16'd0);

        cmd(2'd0, 8'hA5);
        chk("push_lat", 16'(lat), 16'd4);
        chk("push_rsp", {obs_err, obs_data}, {1'b0, 8'hA5});
        cmd(2'd1, 8'h00);
        chk("pop_lat", 16'(lat), 16'd4);
        chk("pop_rsp", {obs_err, obs_data}, {1'b0, 8'hA5});
        cmd(2'd2, 8'h00);
        chk("stat_lat", 16'(lat), 16'd3);
        chk("stat_empty", {obs_err, obs_data}, {1'b0, 8'h02});

        c0 = n_chk;
        a0 = n_a0;
        cmd(2'd1, 8'h00);
        chk("pop_empty_polls", 16'(n_chk - c0), 16'd4);
        chk("pop_empty_no_fifo", 16'(n_a0 - a0), 16'd0);
        chk("pop_empty_rsp", {obs_err, obs_data[1]}, 16'b11);
        chk("pop_empty_lat", 16'(lat), 16'd8);

        for (int i = 0; i < 4; i++) cmd(2'd0, fill[i]);
        a0 = n_a0;
        cmd(2'd0, 8'h3C);
        chk("push_full_rsp", {obs_err, obs_data}, {1'b0, 8'h01} | 16'h100);
        chk("push_full_no_fifo", 16'(n_a0 - a0), 16'd0);
        for (int i = 0; i < 4; i++) begin
            cmd(2'd1, 8'h00);
            chk("drain", {obs_err, obs_data}, {1'b0, fill[i]});
        end

        #1 force_ovf = 1;
        @(negedge clk);
        #1 force_ovf = 0;
        cmd(2'd2, 8'h00);
        chk("stat_ovf", 16'(obs_data), 16'h06);
        w0 = n_clr;
        cmd(2'd3, 8'h00);
        chk("clear_strobe", 16'(n_clr - w0), 16'd1);
        chk("clear_rsp", {obs_err, obs_data}, 16'h0);
        chk("clear_lat", 16'(lat), 16'd3);
        cmd(2'd2, 8'h00);
        chk("stat_after_clear", 16'(obs_data[2]), 16'd0);

        bp_mode = 2;
        send(2'd2, 8'h00);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("bp_hold", {rsp_valid, cmd_ready, rsp_err, rsp_data}, {1'b1, 1'b0, 1'b0, 8'h02});
            @(negedge clk);
        end
        bp_mode = 0;
        wait_rsp();

        cmd(2'd0, 8'h5A);
        send(2'd1, 8'h00);
        @(negedge clk);
        chk("pop_access", {enable, read, write, addr}, 16'b11000);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_outs", {cmd_ready, rsp_valid, enable, read, write, addr, wdata, rsp_err}, 16'h0);
        @(negedge clk);
        #1 rst_n = 1;
        cmd(2'd1, 8'h00);
        chk("post_reset_pop", {obs_err, obs_data}, {1'b0, 8'h5A});

        bp_mode = 1;
        repeat (150) begin
            int r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0) begin
                #1 force_ovf = 1;
                @(negedge clk);
                #1 force_ovf = 0;
            end
            cmd(r < 4 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3, 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/fifo_bus_initiator.md
# fifo_bus_initiator

Bus initiator that drives the register bus of `master_module` (`enable`/`addr`/`write`/`read`/`wdata`/`rdata`) on behalf of an upstream command source. It accepts byte-level commands over a valid/ready handshake and converts each one into bus cycles. Push and pop commands are guarded by a STAT_REG poll, so the FIFO never overflows or underflows. Every command returns exactly one response over a second valid/ready handshake.

## Interface
Parameters:
- `POLL_LIMIT`, default 4, range 1–255: maximum number of status polls before a blocked PUSH/POP is refused with an error.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command; high only in IDLE.
- `cmd_op` in 2: command code. 0 = PUSH, 1 = POP, 2 = STAT, 3 = CLEAR.
- `cmd_data` in 8: byte to push; ignored for the other ops.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response accepted.
- `rsp_data` out 8: response payload.
- `rsp_err` out 1: command refused (FIFO full on PUSH, empty on POP).
- `enable` out 1: bus enable.
- `addr` out 2: bus address. 0 = FIFO, 1 = STAT_REG, 2 = MEM_REG.
- `write` out 1: bus write strobe.
- `read` out 1: bus read strobe.
- `wdata` out 8: bus write data.
- `rdata` in 8: bus read data.

## Operation
- Command transfer: occurs on a rising edge with `cmd_valid && cmd_ready`. The block latches `cmd_op` and `cmd_data` and clears the poll counter (8 bits).
- STAT_REG bits used by this block:
  - bit0 = full
  - bit1 = empty
  - bit4 = clear (write-only trigger)
- States:
  - IDLE: `cmd_ready`=1 and bus idle. On transfer, go to CHK for PUSH/POP, or to ACCESS for STAT/CLEAR.
  - CHK: drive `enable`=1, `read`=1, `addr`=1 and sample `rdata` at the end of the cycle.
    - Blocked if (PUSH and `rdata[0]`) or (POP and `rdata[1]`). If blocked and poll count = `POLL_LIMIT`-1, go to RESP with `rsp_err`=1 and `rsp_data` = sampled status. If blocked otherwise, increment the poll count and go to BACKOFF.
    - If not blocked, go to ACCESS.
  - BACKOFF: one cycle with the bus idle, then go to CHK.
  - ACCESS: one bus cycle, then go to CAPTURE. Drive per op:
    - PUSH: `enable`=1, `write`=1, `addr`=0, `wdata`=latched data.
    - POP: `enable`=1, `read`=1, `addr`=0.
    - STAT: `enable`=1, `read`=1, `addr`=1.
    - CLEAR: `enable`=1, `write`=1, `addr`=1, `wdata`=8'h10.
  - CAPTURE: strobes and `enable` low, `addr` held from ACCESS. Load `rsp_data` per op, set `rsp_err`=0, then go to RESP.
    - POP: `rdata` (the FIFO output updated by the ACCESS edge).
    - STAT: `rdata`.
    - PUSH: echo of the pushed byte.
    - CLEAR: 8'h00.
  - RESP: `rsp_valid`=1. `rsp_data`/`rsp_err` are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Outside CHK/ACCESS: `enable`, `read`, `write` = 0 and `wdata` = 0. Exactly one strobe is ever high at a time.
- Refused commands generate no ACCESS cycle. The FIFO flags are never set by this block.

## Timing
- Reset (asynchronous, immediate): state IDLE, poll count 0. All outputs 0 except `cmd_ready`, which is 1 once `rst_n`=1.
- All outputs are decoded from registered state and data, so they change only after `clk` edges.
- Latency, with accept edge = cycle 0 and `rsp_ready` held high:
  - STAT/CLEAR: ACCESS in cycle 1, CAPTURE in cycle 2, `rsp_valid` in cycle 3.
  - Unblocked PUSH/POP: CHK 1, ACCESS 2, CAPTURE 3, `rsp_valid` 4.
  - Each blocked poll adds 2 cycles (CHK + BACKOFF).
  - Refused command: `rsp_valid` in cycle 2·`POLL_LIMIT`. For example, `POLL_LIMIT`=4 gives CHK in cycles 1, 3, 5, 7 and `rsp_valid` in cycle 8.
- Back-to-back: the next command is accepted in the first IDLE cycle after the response handshake, at a minimum of 1 cycle between them.
- `POLL_LIMIT`=1: a single CHK; if blocked, refuse immediately.
- Reset mid-operation: the bus is released the same instant and any in-flight command and response are discarded. A push whose ACCESS edge already occurred stays in the FIFO.

## Test plan
- Reset, then idle: all bus outputs 0, `rsp_valid`=0, `cmd_ready`=1. No bus activity for 20 cycles without a command.
- PUSH 8'hA5 into an empty FIFO, then POP: PUSH response `rsp_data`=A5, `err`=0 in cycle 4. POP response `rsp_data`=A5, `err`=0. Followed by STAT response with bit1 (empty)=1.
- POP on an empty FIFO with `POLL_LIMIT`=4: exactly 4 CHK cycles, no `addr`=0 strobe, response `err`=1 with `rsp_data[1]`=1 in cycle 8.
- Fill the FIFO to full, then PUSH 8'h3C: refused with `err`=1 and `rsp_data[0]`=1. FIFO contents are unchanged, verified by draining with POPs in order.
- CLEAR after a forced overflow flag: one cycle with `write`=1, `addr`=1, `wdata`=8'h10. A subsequent STAT shows bit2=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles; `rsp_valid`, `rsp_data`, `rsp_err` stay stable and `cmd_ready`=0. Assert `rst_n`=0 during ACCESS of a POP: all outputs drop to 0 immediately and the next command completes normally.
